// File: rtl/udp_image_unpack_pkg.sv
// Package udp_img_pkg: shared constants, FSM encoding and the packet
// acceptance predicate for udp_image_unpack.
//   state_t        one-hot FSM encoding, also driven out on the debug port
//   DEF_PKT_BYTES  default payload bytes per packet (multiple of 4)
//   DEF_PKT_WORDS  default payload words per packet
//   DEF_BUF_AW     default buffer address width
//   BYTE_NUM_W     width of the reported byte count
//   WORD_CNT_W     width of the per-packet word counters
//   pkt_accept()   true when a finished packet may be committed
package udp_img_pkg;

  typedef enum logic [4:0] {
    ST_IDLE      = 5'b00001,
    ST_REQ       = 5'b00010,
    ST_STREAM    = 5'b00100,
    ST_FLUSH     = 5'b01000,
    ST_FRAME_END = 5'b10000
  } state_t;

  localparam int          BYTE_NUM_W    = 16;
  localparam int          WORD_CNT_W    = 16;
  localparam logic [15:0] DEF_PKT_BYTES = 16'd520;
  localparam logic [15:0] DEF_PKT_WORDS = DEF_PKT_BYTES >> 2;
  localparam int          DEF_BUF_AW    = 8;

  // A packet is kept only when the sender's byte count, the number of words
  // actually seen and the expected size all agree, and nothing was lost.
  function automatic logic pkt_accept(
    input logic [BYTE_NUM_W-1:0] byte_num,
    input logic [BYTE_NUM_W-1:0] exp_bytes,
    input logic [WORD_CNT_W-1:0] words,
    input logic                  ovf
  );
    return (byte_num == exp_bytes) && (words == (exp_bytes >> 2)) && !ovf;
  endfunction

endpackage

// File: rtl/udp_image_unpack_if.sv
// udp_image_unpack_if: bundles the UDP RX payload stream and the SDRAM
// write-FIFO handshake.
//   rec_en / rec_data / rec_pkt_done / rec_byte_num   RX payload stream
//   write_req / write_req_ack                          burst request handshake
//   write_en / write_data / almost_full_flag           write FIFO port
// Modports:
//   master  the unpacker (consumes RX, drives the write side)
//   slave   the surrounding system (drives RX, consumes the write side)
interface udp_image_unpack_if;
  logic        rec_en;
  logic [31:0] rec_data;
  logic        rec_pkt_done;
  logic [15:0] rec_byte_num;
  logic        almost_full_flag;
  logic        write_req;
  logic        write_req_ack;
  logic        write_en;
  logic [31:0] write_data;

  modport master (
    input  rec_en, rec_data, rec_pkt_done, rec_byte_num,
    input  almost_full_flag, write_req_ack,
    output write_req, write_en, write_data
  );

  modport slave (
    output rec_en, rec_data, rec_pkt_done, rec_byte_num,
    output almost_full_flag, write_req_ack,
    input  write_req, write_en, write_data
  );
endinterface

// File: rtl/udp_image_unpack_pkt_buf_ram.sv
// pkt_buf_ram: simple dual-port packet buffer, one write port and one read
// port on the same clock, read data registered (1 clk latency).
//   clk      clock
//   wr_en    write strobe, wr_addr / wr_data
//   rd_en    read strobe, rd_addr; rd_data valid the cycle after rd_en
module pkt_buf_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/udp_image_unpack.sv
// udp_image_unpack: receive-side unpacker. Buffers UDP payload packets,
// drops malformed packets whole, and streams committed words to the SDRAM
// write FIFO one frame (udp_num packets) per write burst.
// Ports:
//   sys_clk, sys_rst      clock, synchronous active-high reset
//   udp_num               packets per frame (sampled in IDLE, 0 means 1)
//   bus (master)          RX stream in, write_req/ack + write_en/data out
//   frame_done            1-cycle pulse after a frame has fully drained
//   state                 one-hot FSM state (debug)
//   drop_cnt, ovf_cnt     saturating dropped / overflowed packet counts,
//                         present only when UDP_RX_STAT_EN is defined
module udp_image_unpack
  import udp_img_pkg::*;
#(
  parameter logic [15:0] PKT_BYTES = DEF_PKT_BYTES,
  parameter int          BUF_AW    = DEF_BUF_AW
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] udp_num,
  udp_image_unpack_if.master bus,
  output logic        frame_done,
  output logic [4:0]  state
`ifdef UDP_RX_STAT_EN
  ,
  output logic [15:0] drop_cnt,
  output logic [15:0] ovf_cnt
`endif
);

  localparam logic [WORD_CNT_W-1:0] PKT_WORDS = WORD_CNT_W'(PKT_BYTES >> 2);

  state_t state_reg, state_next;

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [BUF_AW:0]         wr_ptr_reg, rd_ptr_reg, commit_ptr_reg, pkt_base_reg;
  logic [BUF_AW:0]         used, readable, wr_ptr_inc;
  logic [WORD_CNT_W-1:0]   cnt_w_reg, words_now;
  logic                    ovf_reg, ovf_now;
  logic                    full, store, accept, has_data;

  logic [31:0]             pkt_cnt_reg, pkt_cnt_next, num_lat_reg, rd_pkt_reg;
  logic [WORD_CNT_W-1:0]   rd_word_reg;
  logic                    rd_en, rd_ok, rd_v1_reg, write_en_reg, write_req;
  logic [31:0]             write_data_reg, ram_q;

  // ---------------- ingress ----------------
  assign used       = wr_ptr_reg - rd_ptr_reg;
  assign full       = used[BUF_AW];          // used never exceeds the depth
  assign store      = bus.rec_en & ~full;
  assign wr_ptr_inc = wr_ptr_reg + {{BUF_AW{1'b0}}, store};
  // A word arriving together with rec_pkt_done still belongs to the packet.
  assign words_now  = cnt_w_reg + {{(WORD_CNT_W-1){1'b0}}, bus.rec_en};
  assign ovf_now    = ovf_reg | (bus.rec_en & full);
  assign accept     = bus.rec_pkt_done &
                      pkt_accept(bus.rec_byte_num, PKT_BYTES, words_now, ovf_now);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_reg     <= '0;
      commit_ptr_reg <= '0;
      pkt_base_reg   <= '0;
      cnt_w_reg      <= '0;
      ovf_reg        <= 1'b0;
    end else if (bus.rec_pkt_done) begin
      cnt_w_reg <= '0;
      ovf_reg   <= 1'b0;
      if (accept) begin
        wr_ptr_reg     <= wr_ptr_inc;
        commit_ptr_reg <= wr_ptr_inc;
        pkt_base_reg   <= wr_ptr_inc;
      end else begin
        // Rewind: the dropped words stay in RAM but are never committed.
        wr_ptr_reg <= pkt_base_reg;
      end
    end else begin
      wr_ptr_reg <= wr_ptr_inc;
      cnt_w_reg  <= words_now;
      ovf_reg    <= ovf_now;
    end
  end

  pkt_buf_ram #(.AW(BUF_AW), .DW(32)) u_buf (
    .clk     (sys_clk),
    .wr_en   (store),
    .wr_addr (wr_ptr_reg[BUF_AW-1:0]),
    .wr_data (bus.rec_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_reg[BUF_AW-1:0]),
    .rd_data (ram_q)
  );

  // ---------------- egress FSM ----------------
  assign readable = commit_ptr_reg - rd_ptr_reg;
  assign has_data = |readable;
  // Reads stop at the frame boundary (counted in whole packets), so packets
  // accepted early for the next frame stay buffered.
  assign rd_ok    = has_data & ~bus.almost_full_flag & (rd_pkt_reg < num_lat_reg);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    write_req  = 1'b0;
    frame_done = 1'b0;
    rd_en      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (has_data) state_next = ST_REQ;
      end
      ST_REQ: begin
        write_req = 1'b1;
        if (bus.write_req_ack) state_next = ST_STREAM;
      end
      ST_STREAM: begin
        rd_en = rd_ok;
        if (pkt_cnt_reg >= num_lat_reg) state_next = ST_FLUSH;
      end
      ST_FLUSH: begin
        rd_en = rd_ok;
        if ((rd_pkt_reg == num_lat_reg) && !rd_v1_reg && !write_en_reg)
          state_next = ST_FRAME_END;
      end
      ST_FRAME_END: begin
        frame_done = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Packets accepted while a frame is finishing carry over to the next one.
  always_comb begin
    pkt_cnt_next = pkt_cnt_reg;
    if (state_reg == ST_FRAME_END) pkt_cnt_next = pkt_cnt_reg - num_lat_reg;
    if (accept) pkt_cnt_next = pkt_cnt_next + 32'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_ptr_reg     <= '0;
      rd_v1_reg      <= 1'b0;
      write_en_reg   <= 1'b0;
      write_data_reg <= '0;
      rd_word_reg    <= '0;
      rd_pkt_reg     <= '0;
      pkt_cnt_reg    <= '0;
      num_lat_reg    <= '0;
    end else begin
      // Two-stage read pipe: RAM read register, then output register.
      rd_v1_reg      <= rd_en;
      write_en_reg   <= rd_v1_reg;
      write_data_reg <= rd_v1_reg ? ram_q : 32'd0;
      pkt_cnt_reg    <= pkt_cnt_next;
      if (rd_en) begin
        rd_ptr_reg <= rd_ptr_reg + {{BUF_AW{1'b0}}, 1'b1};
        if (rd_word_reg == PKT_WORDS - 1'b1) begin
          rd_word_reg <= '0;
          rd_pkt_reg  <= rd_pkt_reg + 32'd1;
        end else begin
          rd_word_reg <= rd_word_reg + 1'b1;
        end
      end
      if (state_reg == ST_FRAME_END) rd_pkt_reg <= '0;
      if (state_reg == ST_IDLE) num_lat_reg <= (udp_num == 32'd0) ? 32'd1 : udp_num;
    end
  end

  assign bus.write_req  = write_req;
  assign bus.write_en   = write_en_reg;
  assign bus.write_data = write_data_reg;
  assign state          = state_reg;

`ifdef UDP_RX_STAT_EN
  logic [15:0] drop_cnt_reg, ovf_cnt_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      drop_cnt_reg <= '0;
      ovf_cnt_reg  <= '0;
    end else if (bus.rec_pkt_done) begin
      if (!accept && (drop_cnt_reg != 16'hFFFF)) drop_cnt_reg <= drop_cnt_reg + 16'd1;
      if (ovf_now && (ovf_cnt_reg != 16'hFFFF)) ovf_cnt_reg <= ovf_cnt_reg + 16'd1;
    end
  end

  assign drop_cnt = drop_cnt_reg;
  assign ovf_cnt  = ovf_cnt_reg;
`endif

endmodule

// File: tb/tb_udp_image_unpack.sv
// Directed testbench for udp_image_unpack.
module tb_udp_image_unpack;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] udp_num;
  logic        frame_done;
  logic [4:0]  state;
`ifdef UDP_RX_STAT_EN
  logic [15:0] drop_cnt, ovf_cnt;
`endif

  udp_image_unpack_if bus_if ();

  udp_image_unpack dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .udp_num    (udp_num),
    .bus        (bus_if),
    .frame_done (frame_done),
    .state      (state)
`ifdef UDP_RX_STAT_EN
    ,
    .drop_cnt   (drop_cnt),
    .ovf_cnt    (ovf_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] out_q[$];
  logic [31:0] exp_q[$];
  int  frame_cnt = 0, req_cnt = 0, cycle = 0;
  int  ack_cyc = 0, lat = 0, af_run = 0, af_viol = 0;
  bit  lat_armed = 0, req_prev = 0;
  bit  ack_enable = 1, af_en = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge.
  initial begin
    forever begin
      @(negedge sys_clk);
      cycle++;
      if (bus_if.write_en) out_q.push_back(bus_if.write_data);
      if (frame_done) begin
        frame_cnt++;
        $display("frame_done #%0d at cycle %0d", frame_cnt, cycle);
      end
      if (bus_if.write_req && !req_prev) req_cnt++;
      req_prev = bus_if.write_req;
      if (bus_if.write_req_ack && bus_if.write_req) begin
        ack_cyc = cycle;
        lat_armed = 1;
      end
      if (bus_if.write_en && lat_armed) begin
        lat = cycle - ack_cyc;
        lat_armed = 0;
      end
      if (bus_if.almost_full_flag) af_run++; else af_run = 0;
      if (bus_if.write_en && af_run >= 3) af_viol++;
    end
  end

  // Acknowledge responder: one-cycle ack when enabled.
  initial begin
    bus_if.write_req_ack = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      bus_if.write_req_ack = ack_enable && bus_if.write_req && !bus_if.write_req_ack;
    end
  end

  // almost_full toggler: flips every 7 clk while enabled.
  initial begin
    int cnt;
    cnt = 0;
    bus_if.almost_full_flag = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      if (af_en) begin
        cnt++;
        if (cnt == 7) begin
          bus_if.almost_full_flag = ~bus_if.almost_full_flag;
          cnt = 0;
        end
      end else begin
        bus_if.almost_full_flag = 1'b0;
        cnt = 0;
      end
    end
  end

  // mode 0: done one cycle after last word; 1: done with last word; 2: no done
  task automatic send_pkt(input logic [31:0] base, input int nwords,
                          input logic [15:0] nbytes, input int mode, input bit good);
    for (int i = 0; i < nwords; i++) begin
      @(posedge sys_clk); #1;
      bus_if.rec_en   = 1'b1;
      bus_if.rec_data = base + 32'(i);
      if (mode == 1 && i == nwords - 1) begin
        bus_if.rec_pkt_done = 1'b1;
        bus_if.rec_byte_num = nbytes;
      end
      if (good) exp_q.push_back(base + 32'(i));
    end
    @(posedge sys_clk); #1;
    bus_if.rec_en   = 1'b0;
    bus_if.rec_data = '0;
    if (mode == 0) begin
      bus_if.rec_pkt_done = 1'b1;
      bus_if.rec_byte_num = nbytes;
      @(posedge sys_clk); #1;
    end
    bus_if.rec_pkt_done = 1'b0;
    bus_if.rec_byte_num = '0;
    $display("packet base=%08h words=%0d bytes=%0d mode=%0d", base, nwords, nbytes, mode);
  endtask

  task automatic wait_frame(input int target, input int budget);
    int i;
    i = 0;
    while (frame_cnt < target && i < budget) begin
      @(posedge sys_clk);
      i++;
    end
    repeat (10) @(posedge sys_clk);
  endtask

  task automatic check_stream(input string tag, input int start);
    int bad;
    bad = 0;
    check_val({tag, "_count"}, 32'(out_q.size() - start), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (start + i >= out_q.size()) bad++;
      else if (out_q[start + i] !== exp_q[i]) bad++;
    end
    check_val({tag, "_bad_words"}, 32'(bad), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, f0, r0;
    sys_rst = 1'b1;
    udp_num = 32'd2;
    bus_if.rec_en = 1'b0;
    bus_if.rec_data = '0;
    bus_if.rec_pkt_done = 1'b0;
    bus_if.rec_byte_num = '0;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_val("rst_write_req", 32'(bus_if.write_req), 32'd0);
    check_val("rst_write_en", 32'(bus_if.write_en), 32'd0);
    check_val("rst_write_data", bus_if.write_data, 32'd0);
    check_val("rst_frame_done", 32'(frame_done), 32'd0);
    check_val("rst_state", 32'(state), 32'd1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;

    // 1) two good packets, udp_num=2
    s0 = out_q.size(); f0 = frame_cnt; r0 = req_cnt;
    send_pkt(32'h0001_0000, 130, 16'd520, 0, 1);
    send_pkt(32'h0002_0000, 130, 16'd520, 0, 1);
    wait_frame(f0 + 1, 2000);
    check_stream("t1", s0);
    check_val("t1_req_once", 32'(req_cnt - r0), 32'd1);
    check_val("t1_frame_done", 32'(frame_cnt - f0), 32'd1);
    check_val("t1_latency_ge3", 32'(lat >= 3), 32'd1);

    // 2) short packet dropped, good packet kept, udp_num=1
    udp_num = 32'd1;
    s0 = out_q.size(); f0 = frame_cnt;
    send_pkt(32'h0003_0000, 129, 16'd516, 0, 0);
    send_pkt(32'h0004_0000, 130, 16'd520, 0, 1);
    wait_frame(f0 + 1, 2000);
    check_stream("t2", s0);
    check_val("t2_frame_done", 32'(frame_cnt - f0), 32'd1);
`ifdef UDP_RX_STAT_EN
    check_val("t2_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

    // 3) ack held low while 260 words arrive: second packet overflows
    ack_enable = 0;
    s0 = out_q.size(); f0 = frame_cnt; r0 = req_cnt;
    send_pkt(32'h0005_0000, 130, 16'd520, 0, 1);
    send_pkt(32'h0006_0000, 130, 16'd520, 0, 0);
    repeat (50) @(posedge sys_clk);
    @(negedge sys_clk);
    check_val("t3_no_words_while_held", 32'(out_q.size() - s0), 32'd0);
    check_val("t3_req_held", 32'(bus_if.write_req), 32'd1);
    ack_enable = 1;
    wait_frame(f0 + 1, 2000);
    repeat (20) @(posedge sys_clk);
    check_stream("t3", s0);
    check_val("t3_req_once", 32'(req_cnt - r0), 32'd1);
`ifdef UDP_RX_STAT_EN
    check_val("t3_drop_cnt", 32'(drop_cnt), 32'd2);
    check_val("t3_ovf_cnt", 32'(ovf_cnt), 32'd1);
`endif
    s0 = out_q.size(); f0 = frame_cnt;
    send_pkt(32'h0007_0000, 130, 16'd520, 0, 1);
    wait_frame(f0 + 1, 2000);
    check_stream("t3_after", s0);

    // 4) almost_full toggling during the stream
    udp_num = 32'd2;
    af_en = 1;
    s0 = out_q.size(); f0 = frame_cnt; af_viol = 0;
    send_pkt(32'h0008_0000, 130, 16'd520, 0, 1);
    send_pkt(32'h0009_0000, 130, 16'd520, 0, 1);
    wait_frame(f0 + 1, 4000);
    af_en = 0;
    check_stream("t4", s0);
    check_val("t4_af_stall", 32'(af_viol), 32'd0);
    check_val("t4_frame_done", 32'(frame_cnt - f0), 32'd1);

    // 5) reset mid-packet with a request pending
    udp_num = 32'd1;
    ack_enable = 0;
    send_pkt(32'h000A_0000, 130, 16'd520, 0, 0);
    send_pkt(32'h000B_0000, 60, 16'd520, 2, 0);
    @(negedge sys_clk);
    check_val("t5_req_before_rst", 32'(bus_if.write_req), 32'd1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check_val("t5_rst_write_req", 32'(bus_if.write_req), 32'd0);
    check_val("t5_rst_write_en", 32'(bus_if.write_en), 32'd0);
    check_val("t5_rst_write_data", bus_if.write_data, 32'd0);
    check_val("t5_rst_frame_done", 32'(frame_done), 32'd0);
    check_val("t5_rst_state", 32'(state), 32'd1);
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    ack_enable = 1;
    s0 = out_q.size(); f0 = frame_cnt;
    send_pkt(32'h000C_0000, 130, 16'd520, 0, 1);
    wait_frame(f0 + 1, 2000);
    check_stream("t5", s0);
    check_val("t5_frame_done", 32'(frame_cnt - f0), 32'd1);

    // 6) rec_pkt_done coincident with the last word
    s0 = out_q.size(); f0 = frame_cnt;
    send_pkt(32'h000D_0000, 130, 16'd520, 1, 1);
    wait_frame(f0 + 1, 2000);
    if (out_q.size() >= s0 + 130) check_val("t6_last_word", out_q[s0 + 129], 32'h000D_0081);
    else check_val("t6_last_word_present", 32'(out_q.size() - s0), 32'd130);
    check_stream("t6", s0);
    check_val("t6_frame_done", 32'(frame_cnt - f0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
